lut_rev_search: RTL and testbench

//  Reverse lookup for the data-memory address table: given an 8-bit dm address, returns
//  the lowest 5-bit pointer whose table entry holds that address.

---
 rtl/lut_rev_search.sv | 132 +++++++++++++
 tb/tb_lut_rev_search.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_rev_search.sv
// Reverse lookup over a writable 32x8 dm-address table: sequential scan from index 0 for the lowest matching pointer.
// Define LUT_REV_CACHE_EN to add a one-entry last-hit cache that answers a repeated key after a single cycle.
module lut_rev_search #(
  parameter int DEPTH  = 32,
  parameter int PTR_W  = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [PTR_W-1:0]  rsp_ptr,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] tbl [DEPTH];
  logic [DATA_W-1:0] key;
  logic [PTR_W-1:0]  idx;
  logic              hit_q;
  logic [PTR_W-1:0]  ptr_q;
  logic              accept;
  logic              last_idx;
  logic              match;
  logic              scan_hit;
  logic [PTR_W-1:0]  scan_ptr;
  logic              use_cache;
  logic [PTR_W-1:0]  cache_ptr;

  // The compare reads the registered table, so a same-cycle write is seen one cycle later.
  assign last_idx = (idx == PTR_W'(DEPTH - 1));
  assign match    = (tbl[idx] == key);
  assign scan_hit = use_cache | match;
  assign scan_ptr = use_cache ? cache_ptr : idx;
  assign rsp_hit  = hit_q;
  assign rsp_ptr  = ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: if (scan_hit || last_idx) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      tbl[0] <= DATA_W'(14);
      tbl[1] <= DATA_W'(20);
      tbl[2] <= DATA_W'(127);
      key    <= '0;
      idx    <= '0;
      hit_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      if (wr_en) tbl[wr_ptr] <= wr_data;
      if (accept) begin
        key <= req_val;
        idx <= '0;
      end
      if (state == SCAN) begin
        if (scan_hit) begin
          hit_q <= 1'b1;
          ptr_q <= scan_ptr;
        end else if (last_idx) begin
          hit_q <= 1'b0;
          ptr_q <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

`ifdef LUT_REV_CACHE_EN
  logic              cache_vld;
  logic [DATA_W-1:0] cache_key;

  // A cached request still spends one cycle in SCAN so its response timing matches an index-0 hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld <= 1'b0;
      cache_key <= '0;
      cache_ptr <= '0;
      use_cache <= 1'b0;
    end else begin
      if (accept) use_cache <= cache_vld && (req_val == cache_key);
      if (wr_en) begin
        cache_vld <= 1'b0;
      end else if (state == SCAN && scan_hit) begin
        cache_vld <= 1'b1;
        cache_key <= key;
        cache_ptr <= scan_ptr;
      end
    end
  end
`else
  assign use_cache = 1'b0;
  assign cache_ptr = '0;
`endif

endmodule

// File: tb/tb_lut_rev_search.sv
// Scoreboard bench for lut_rev_search: a table/cache model predicts hit, pointer and response latency per request.
module tb_lut_rev_search;
  localparam int DEPTH = 32;
`ifdef LUT_REV_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_ptr = '0;
  logic [7:0] wr_data = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_val = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_hit;
  logic [4:0] rsp_ptr;
  logic       busy;

  lut_rev_search dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_val(req_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_ptr(rsp_ptr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit hit;
    int ptr;
    int lat;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         acc_edge = 0;
  logic [7:0] ref_tbl [DEPTH];
  bit         m_cvld;
  logic [7:0] m_ckey;
  int         m_cptr;

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic ref_reset();
    for (int j = 0; j < DEPTH; j++) ref_tbl[j] = 8'd0;
    ref_tbl[0] = 8'd14;
    ref_tbl[1] = 8'd20;
    ref_tbl[2] = 8'd127;
    m_cvld = 1'b0;
  endtask

  task automatic do_write(input int p, input int d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_ptr = 5'(p);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
    ref_tbl[p] = 8'(d);
    m_cvld = 1'b0;
  endtask

  // wr_at >= 0 schedules a write during the cycle the engine compares index wr_at.
  task automatic issue(input int k, input int wr_at, input int wp, input int wd, input int hold);
    exp_t e;
    logic [7:0] v;
    bit wr_issued;
    bit all_busy;
    int c;
    e.hit = 1'b0;
    e.ptr = 0;
    e.lat = DEPTH;
    if (CACHE && m_cvld && m_ckey == 8'(k)) begin
      e.hit = 1'b1;
      e.ptr = m_cptr;
      e.lat = 1;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        v = (wr_at >= 0 && j > wr_at && j == wp) ? 8'(wd) : ref_tbl[j];
        if (!e.hit && v == 8'(k)) begin
          e.hit = 1'b1;
          e.ptr = j;
          e.lat = j + 1;
        end
      end
    end
    wr_issued = (wr_at >= 0) && (e.lat > wr_at);
    if (wr_issued) ref_tbl[wp] = 8'(wd);
    if (e.hit) begin
      if (wr_issued && e.lat == wr_at + 1) m_cvld = 1'b0;
      else begin
        m_cvld = 1'b1;
        m_ckey = 8'(k);
        m_cptr = e.ptr;
      end
    end else if (wr_issued) begin
      m_cvld = 1'b0;
    end
    q.push_back(e);

    @(negedge clk);
    req_valid = 1'b1;
    req_val = 8'(k);
    @(negedge clk);
    req_valid = 1'b0;
    acc_edge = cyc;
    c = 0;
    all_busy = 1'b1;
    while (!rsp_valid && c < 40) begin
      if (c == wr_at) begin
        wr_en = 1'b1;
        wr_ptr = 5'(wp);
        wr_data = 8'(wd);
      end
      if (busy !== 1'b1) all_busy = 1'b0;
      @(negedge clk);
      wr_en = 1'b0;
      c++;
    end
    chk($sformatf("busy_during_search key=%0d", k), int'(all_busy), 1);
    if (!rsp_valid) begin
      chk($sformatf("rsp_timeout key=%0d", k), 0, 1);
      void'(q.pop_back());
    end else begin
      repeat (hold) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_after_consume", int'({req_ready, rsp_valid, busy}), 3'b100);
    end
  endtask

  // Monitor: pops on each new response, checks stability while the response is held.
  initial begin
    exp_t e;
    bit prev_vld;
    bit held_hit;
    logic [4:0] held_ptr;
    prev_vld = 1'b0;
    held_hit = 1'b0;
    held_ptr = '0;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && !prev_vld) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp hit=%0d ptr=%0d", rsp_hit, rsp_ptr);
        end else begin
          e = q.pop_front();
          if (rsp_hit !== e.hit || int'(rsp_ptr) != e.ptr || (cyc - acc_edge) != e.lat || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsp got hit=%0d ptr=%0d lat=%0d rdy=%0d want hit=%0d ptr=%0d lat=%0d rdy=0",
                     rsp_hit, rsp_ptr, cyc - acc_edge, req_ready, e.hit, e.ptr, e.lat);
          end
        end
        held_hit = rsp_hit;
        held_ptr = rsp_ptr;
      end else if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_hit !== held_hit || rsp_ptr !== held_ptr || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL rsp_hold got hit=%0d ptr=%0d rdy=%0d want hit=%0d ptr=%0d rdy=0",
                   rsp_hit, rsp_ptr, req_ready, held_hit, held_ptr);
        end
      end
      prev_vld = (rsp_valid === 1'b1);
    end
  end

  initial begin
    ref_reset();
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({req_ready, rsp_valid, rsp_hit, rsp_ptr, busy}), 9'b1_0_0_00000_0);
    reset = 1'b0;
    @(negedge clk);
    chk("after_release", int'({req_ready, rsp_valid, busy}), 3'b100);

    issue(20, -1, 0, 0, 0);
    issue(14, -1, 0, 0, 0);
    issue(0, -1, 0, 0, 0);
    issue(99, -1, 0, 0, 0);
    issue(99, 10, 31, 99, 0);
    issue(99, 10, 5, 99, 0);
    issue(20, -1, 0, 0, 5);

    // Abort a scan with reset: no response may follow and presets must return.
    @(negedge clk);
    req_valid = 1'b1;
    req_val = 8'd99;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_mid_scan", int'({req_ready, rsp_valid, busy}), 3'b100);
    @(negedge clk);
    reset = 1'b0;
    ref_reset();
    repeat (40) @(negedge clk);
    issue(127, -1, 0, 0, 0);
    issue(99, -1, 0, 0, 0);

    issue(127, -1, 0, 0, 1);
    issue(127, -1, 0, 0, 0);
    do_write(2, 5);
    issue(127, -1, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int k;
      int wa;
      if ($urandom_range(0, 2) == 0) do_write(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
      k = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 15));
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
      issue(k, wa, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
